// File: rtl/axilite_pkg.sv
// Shared types for the AXI-Lite command sequencer.
// FSM state encoding, queued command bundle and default queue depth.
package axilite_pkg;

  localparam int unsigned CMD_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

endpackage

// File: rtl/axilite_cmd_fifo.sv
// Command queue for the sequencer: DEPTH entries, show-ahead head,
// no bypass, push refused when full even if a pop occurs.
module axilite_cmd_fifo
  import axilite_pkg::*;
#(
  parameter int unsigned DEPTH = CMD_DEPTH_DEFAULT
) (
  input  logic                     axi_aclk,
  input  logic                     axi_areset,
  input  logic                     push,
  input  cmd_t                     din,
  input  logic                     pop,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge axi_aclk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axilite_cmd_sequencer.sv
// Queues AXI-Lite read/write commands and issues them one at a time
// to a master backend, returning in-order responses.
module axilite_cmd_sequencer
  import axilite_pkg::*;
#(
  parameter int unsigned DEPTH = CMD_DEPTH_DEFAULT
) (
  input  logic                   axi_aclk,
  input  logic                   axi_areset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [31:0]            cmd_addr,
  input  logic [31:0]            cmd_wdata,
  input  logic [3:0]             cmd_wstrb,
  output logic                   bk_wstart,
  output logic [31:0]            bk_waddr,
  output logic [31:0]            bk_wdata,
  output logic [3:0]             bk_wstrb,
  input  logic                   bk_wdone,
  output logic                   bk_rstart,
  output logic [31:0]            bk_raddr,
  input  logic [31:0]            bk_rdata,
  input  logic                   bk_rdone,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_wr,
  output logic [31:0]            rsp_rdata,
  output logic [$clog2(DEPTH):0] cmd_level
);

  seq_state_t state;
  cmd_t       cmd_in;
  cmd_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       busy;
  logic       wdone_hit;
  logic       rdone_hit;

  assign cmd_in.wr    = cmd_wr;
  assign cmd_in.addr  = cmd_addr;
  assign cmd_in.wdata = cmd_wdata;
  assign cmd_in.wstrb = cmd_wstrb;

  assign cmd_ready = !fifo_full && !axi_areset;
  assign pop       = (state == ST_IDLE) && !fifo_empty;

  axilite_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .push       (cmd_valid && cmd_ready),
    .din        (cmd_in),
    .pop        (pop),
    .dout       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (cmd_level)
  );

  // rsp_wr doubles as the type of the command in flight
  assign busy      = (state == ST_ISSUE) || (state == ST_WAIT_DONE);
  assign wdone_hit = busy && rsp_wr && bk_wdone;
  assign rdone_hit = busy && !rsp_wr && bk_rdone;

  assign bk_wstart = (state == ST_ISSUE) && rsp_wr;
  assign bk_rstart = (state == ST_ISSUE) && !rsp_wr;
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state     <= ST_IDLE;
      bk_waddr  <= '0;
      bk_wdata  <= '0;
      bk_wstrb  <= '0;
      bk_raddr  <= '0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            state  <= ST_ISSUE;
            rsp_wr <= head.wr;
            if (head.wr) begin
              bk_waddr <= head.addr;
              bk_wdata <= head.wdata;
              bk_wstrb <= head.wstrb;
            end else begin
              bk_raddr <= head.addr;
            end
          end
        end
        ST_ISSUE, ST_WAIT_DONE: begin
          if (wdone_hit) begin
            state     <= ST_RESP;
            rsp_rdata <= '0;
          end else if (rdone_hit) begin
            state     <= ST_RESP;
            rsp_rdata <= bk_rdata;
          end else begin
            state <= ST_WAIT_DONE;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_cmd_sequencer.sv
// Directed bench for axilite_cmd_sequencer: latency, ordering,
// fill, backpressure, stray dones and reset recovery.
module tb_axilite_cmd_sequencer;

  logic        axi_aclk = 1'b0;
  logic        axi_areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        bk_wstart;
  logic [31:0] bk_waddr;
  logic [31:0] bk_wdata;
  logic [3:0]  bk_wstrb;
  logic        bk_wdone = 1'b0;
  logic        bk_rstart;
  logic [31:0] bk_raddr;
  logic [31:0] bk_rdata = '0;
  logic        bk_rdone = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic [31:0] rsp_rdata;
  logic [2:0]  cmd_level;

  int tests = 0;
  int fails = 0;

  always #5 axi_aclk = ~axi_aclk;

  axilite_cmd_sequencer #(.DEPTH(4)) dut (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .bk_wstart  (bk_wstart),
    .bk_waddr   (bk_waddr),
    .bk_wdata   (bk_wdata),
    .bk_wstrb   (bk_wstrb),
    .bk_wdone   (bk_wdone),
    .bk_rstart  (bk_rstart),
    .bk_raddr   (bk_raddr),
    .bk_rdata   (bk_rdata),
    .bk_rdone   (bk_rdone),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_wr     (rsp_wr),
    .rsp_rdata  (rsp_rdata),
    .cmd_level  (cmd_level)
  );

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic push_cmd(input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int k;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin
      tick();
      k++;
    end
    if (k >= 20) begin
      tests++;
      fails++;
      $display("FAIL push_timeout addr=%h", a);
    end else begin
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!(bk_wstart || bk_rstart) && n < 16) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    axi_areset = 1'b1;
    repeat (3) tick();
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL rst_ready got=%b exp=0", cmd_ready);
    end
    tests++;
    if (cmd_level !== 3'd0) begin
      fails++; $display("FAIL rst_level got=%0d exp=0", cmd_level);
    end
    tests++;
    if ({bk_wstart, bk_rstart, rsp_valid, rsp_wr} !== 4'b0) begin
      fails++;
      $display("FAIL rst_flags got=%b exp=0000",
               {bk_wstart, bk_rstart, rsp_valid, rsp_wr});
    end
    tests++;
    if ({bk_waddr, bk_wdata, bk_wstrb, bk_raddr, rsp_rdata} !== '0) begin
      fails++;
      $display("FAIL rst_data waddr=%h raddr=%h rdata=%h exp=0",
               bk_waddr, bk_raddr, rsp_rdata);
    end
    axi_areset = 1'b0;
    tick();
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL post_rst_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_single_write();
    cmd_wr    = 1'b1;
    cmd_addr  = 32'h3000_0010;
    cmd_wdata = 32'hDEAD_BEEF;
    cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL wr_accept got=%b exp=1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    tests++;
    if (bk_wstart !== 1'b0 || cmd_level !== 3'd1) begin
      fails++;
      $display("FAIL wr_t1 wstart=%b level=%0d exp 0/1", bk_wstart, cmd_level);
    end
    tick();
    tests++;
    if (bk_wstart !== 1'b1 || bk_rstart !== 1'b0) begin
      fails++;
      $display("FAIL wr_t2_start w=%b r=%b exp 1/0", bk_wstart, bk_rstart);
    end
    tests++;
    if (bk_waddr !== 32'h3000_0010 || bk_wdata !== 32'hDEAD_BEEF ||
        bk_wstrb !== 4'hF) begin
      fails++;
      $display("FAIL wr_fields got=%h/%h/%h exp=30000010/deadbeef/f",
               bk_waddr, bk_wdata, bk_wstrb);
    end
    tick();
    tests++;
    if (bk_wstart !== 1'b0) begin
      fails++; $display("FAIL wr_pulse_len got=%b exp=0", bk_wstart);
    end
    tick();
    tick();
    tick();
    bk_wdone = 1'b1;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL wr_early_rsp got=%b exp=0", rsp_valid);
    end
    tick();
    bk_wdone = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL wr_rsp got v=%b wr=%b d=%h exp 1/1/0",
               rsp_valid, rsp_wr, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++; $display("FAIL wr_rsp_drop got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_single_read();
    int n;
    push_cmd(1'b0, 32'h3000_0020, 32'hFFFF_FFFF, 4'h3);
    wait_start(n);
    tests++;
    if (n !== 1 || bk_rstart !== 1'b1 || bk_raddr !== 32'h3000_0020) begin
      fails++;
      $display("FAIL rd_start n=%0d rstart=%b raddr=%h exp 1/1/30000020",
               n, bk_rstart, bk_raddr);
    end
    tests++;
    if (bk_waddr !== 32'h3000_0010 || bk_wdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL rd_whold got=%h/%h exp=30000010/deadbeef",
               bk_waddr, bk_wdata);
    end
    tick();
    bk_rdone = 1'b1;
    bk_rdata = 32'h1234_5678;
    tick();
    bk_rdone = 1'b0;
    bk_rdata = 32'h0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_wr !== 1'b0 ||
        rsp_rdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL rd_rsp got v=%b wr=%b d=%h exp 1/0/12345678",
               rsp_valid, rsp_wr, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_issue_done();
    int n;
    push_cmd(1'b1, 32'h0000_0003, 32'h0102_0304, 4'h5);
    wait_start(n);
    tests++;
    if (n !== 1 || bk_wstart !== 1'b1) begin
      fails++; $display("FAIL iss_start n=%0d w=%b exp 1/1", n, bk_wstart);
    end
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1) begin
      fails++;
      $display("FAIL iss_done_rsp v=%b wr=%b exp 1/1", rsp_valid, rsp_wr);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        f_wr    [5];
    logic [31:0] f_addr  [5];
    logic [31:0] f_data  [5];
    logic [3:0]  f_strb  [5];
    logic [31:0] f_rdata [5];
    logic [31:0] a;
    int n;
    for (int i = 0; i < 5; i++) begin
      f_wr[i]    = (i % 2) == 0;
      f_addr[i]  = 32'h4000_0000 + 32'(i * 4);
      f_data[i]  = 32'hA0A0_0000 + 32'(i);
      f_strb[i]  = 4'(i + 1);
      f_rdata[i] = 32'h5555_0000 + 32'(i);
    end
    push_cmd(f_wr[0], f_addr[0], f_data[0], f_strb[0]);
    wait_start(n);
    tick();
    for (int i = 1; i < 5; i++) begin
      push_cmd(f_wr[i], f_addr[i], f_data[i], f_strb[i]);
    end
    cmd_wr    = 1'b0;
    cmd_addr  = 32'h7777_7777;
    cmd_valid = 1'b1;
    tests++;
    if (cmd_ready !== 1'b0 || cmd_level !== 3'd4) begin
      fails++;
      $display("FAIL fill_full ready=%b level=%0d exp 0/4",
               cmd_ready, cmd_level);
    end
    tick();
    cmd_valid = 1'b0;
    tests++;
    if (cmd_level !== 3'd4) begin
      fails++; $display("FAIL fill_hold level=%0d exp=4", cmd_level);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        wait_start(n);
        a = f_wr[i] ? bk_waddr : bk_raddr;
        tests++;
        if (n !== 1 || bk_wstart !== f_wr[i] || bk_rstart !== !f_wr[i]) begin
          fails++;
          $display("FAIL b2b_start%0d n=%0d w=%b r=%b exp n=1 wr=%b",
                   i, n, bk_wstart, bk_rstart, f_wr[i]);
        end
        tests++;
        if (a !== f_addr[i] || cmd_level !== 3'(4 - i)) begin
          fails++;
          $display("FAIL b2b_addr%0d got=%h lvl=%0d exp=%h/%0d",
                   i, a, cmd_level, f_addr[i], 4 - i);
        end
        if (f_wr[i]) begin
          tests++;
          if (bk_wdata !== f_data[i] || bk_wstrb !== f_strb[i]) begin
            fails++;
            $display("FAIL b2b_wdata%0d got=%h/%h exp=%h/%h",
                     i, bk_wdata, bk_wstrb, f_data[i], f_strb[i]);
          end
        end
        tick();
      end
      if (f_wr[i]) begin
        bk_wdone = 1'b1;
      end else begin
        bk_rdone = 1'b1;
        bk_rdata = f_rdata[i];
      end
      tick();
      bk_wdone = 1'b0;
      bk_rdone = 1'b0;
      bk_rdata = 32'h0;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_wr !== f_wr[i] ||
          rsp_rdata !== (f_wr[i] ? 32'h0 : f_rdata[i])) begin
        fails++;
        $display("FAIL b2b_rsp%0d v=%b wr=%b d=%h exp wr=%b",
                 i, rsp_valid, rsp_wr, rsp_rdata, f_wr[i]);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int n;
    push_cmd(1'b0, 32'h3000_0030, 32'h0, 4'h0);
    wait_start(n);
    tick();
    bk_rdone = 1'b1;
    bk_rdata = 32'hCAFE_F00D;
    tick();
    bk_rdone = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bk_rdone = (i == 4);
      bk_rdata = 32'h0BAD_0BAD;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin
        fails++;
        $display("FAIL bp_hold%0d v=%b d=%h exp 1/cafef00d",
                 i, rsp_valid, rsp_rdata);
      end
      tick();
    end
    bk_rdone = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    push_cmd(1'b1, 32'h3000_0034, 32'h1111_2222, 4'h8);
    wait_start(n);
    tick();
    bk_rdone = 1'b1;
    tick();
    bk_rdone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("FAIL stray_rdone%0d v=%b exp=0", i, rsp_valid);
      end
      tick();
    end
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_wr !== 1'b1 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL stray_wr_rsp v=%b wr=%b d=%h exp 1/1/0",
               rsp_valid, rsp_wr, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    bk_wdone = 1'b1;
    bk_rdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    bk_rdone = 1'b0;
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || bk_wstart !== 1'b0 || bk_rstart !== 1'b0) begin
      fails++;
      $display("FAIL idle_done v=%b w=%b r=%b exp 0/0/0",
               rsp_valid, bk_wstart, bk_rstart);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    push_cmd(1'b1, 32'h3000_0100, 32'h5A5A_5A5A, 4'hC);
    wait_start(n);
    tick();
    push_cmd(1'b0, 32'h3000_0104, 32'h0, 4'h0);
    push_cmd(1'b1, 32'h3000_0108, 32'h1, 4'h1);
    tests++;
    if (cmd_level !== 3'd2) begin
      fails++; $display("FAIL mid_level got=%0d exp=2", cmd_level);
    end
    axi_areset = 1'b1;
    tick();
    tests++;
    if (cmd_level !== 3'd0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_rst lvl=%0d rdy=%b v=%b exp 0/0/0",
               cmd_level, cmd_ready, rsp_valid);
    end
    tests++;
    if (bk_waddr !== 32'h0 || bk_wdata !== 32'h0 || bk_wstrb !== 4'h0) begin
      fails++;
      $display("FAIL mid_rst_bk got=%h/%h/%h exp 0", bk_waddr, bk_wdata,
               bk_wstrb);
    end
    axi_areset = 1'b0;
    bk_wdone = 1'b1;
    tick();
    bk_wdone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rsp_valid !== 1'b0 || bk_wstart !== 1'b0 || bk_rstart !== 1'b0) begin
        fails++;
        $display("FAIL mid_quiet%0d v=%b w=%b r=%b exp 0", i, rsp_valid,
                 bk_wstart, bk_rstart);
      end
      tick();
    end
    push_cmd(1'b0, 32'h3000_0040, 32'h0, 4'h0);
    wait_start(n);
    tests++;
    if (n !== 1 || bk_rstart !== 1'b1 || bk_raddr !== 32'h3000_0040) begin
      fails++;
      $display("FAIL fresh_start n=%0d r=%b a=%h exp 1/1/30000040",
               n, bk_rstart, bk_raddr);
    end
    tick();
    bk_rdone = 1'b1;
    bk_rdata = 32'h0BAD_CAFE;
    tick();
    bk_rdone = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_wr !== 1'b0 ||
        rsp_rdata !== 32'h0BAD_CAFE) begin
      fails++;
      $display("FAIL fresh_rsp v=%b wr=%b d=%h exp 1/0/0badcafe",
               rsp_valid, rsp_wr, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_issue_done();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axilite_cmd_sequencer.md
AXILITE_CMD_SEQUENCER -- requirements
Module: axilite_cmd_sequencer

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-003 axi_areset  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid  in  1  upstream command valid.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_wr  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  32  target address.
REQ-008 cmd_wdata  in  32  write data (ignored for reads).
REQ-009 cmd_wstrb  in  4  write strobes (ignored for reads).
REQ-010 bk_wstart  out  1  single-cycle write trigger to the AXI-Lite master backend.
REQ-011 bk_waddr / bk_wdata / bk_wstrb  out  32/32/4  write command to the master.
REQ-012 bk_wdone  in  1  single-cycle write completion from the master.
REQ-013 bk_rstart  out  1  single-cycle read trigger.
REQ-014 bk_raddr  out  32  read address.
REQ-015 bk_rdata  in  32  read data, valid in the bk_rdone cycle.
REQ-016 bk_rdone  in  1  single-cycle read completion.
REQ-017 rsp_valid  out  1  response valid.
REQ-018 rsp_ready  in  1  response accepted when rsp_valid && rsp_ready.
REQ-019 rsp_wr  out  1  type of the completed command.
REQ-020 rsp_rdata  out  32  read data; 0 for write responses.
REQ-021 cmd_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-022 Accepted commands SHALL be written into a DEPTH-entry FIFO; cmd_ready = !full, with no bypass and no push when full, even when a pop occurs in the same cycle.
REQ-023 Exactly one command SHALL be outstanding at a time; commands SHALL be issued and responded to strictly in acceptance order.
REQ-024 FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
REQ-025 IDLE -> ISSUE when the FIFO is non-empty; on this transition the head SHALL be popped into the current-command registers.
REQ-026 In ISSUE, bk_wstart (write) or bk_rstart (read) SHALL be 1 for exactly one cycle; the next state is WAIT_DONE.
REQ-027 bk_waddr/bk_wdata/bk_wstrb/bk_raddr SHALL be driven from the current-command registers, stable from ISSUE until the next ISSUE. The unused-direction outputs hold their previous value.
REQ-028 WAIT_DONE -> RESP on bk_wdone for a write, or on bk_rdone for a read. In the bk_rdone cycle bk_rdata SHALL be captured into rsp_rdata.
REQ-029 A done of the non-matching type, or any done in IDLE or RESP, SHALL be ignored.
REQ-030 A matching done sampled during ISSUE SHALL be honoured (ISSUE -> RESP).
REQ-031 In RESP, rsp_valid = 1 and rsp_wr/rsp_rdata SHALL be held until rsp_ready; then -> IDLE.
REQ-032 Latency with an empty FIFO in IDLE: command accepted at cycle T -> start pulse at T+2. Done at cycle D -> rsp_valid at D+1.
REQ-033 Back-to-back throughput: after the response handshake at cycle R with the FIFO non-empty, the next start pulse SHALL occur at R+2.
REQ-034 Address and data SHALL be forwarded unmodified; no alignment checks are performed.
REQ-035 cmd_level SHALL increment on push, decrement on pop, and stay unchanged on simultaneous push and pop; read and write pointers wrap modulo DEPTH.

Reset
REQ-036 While axi_areset is 1 at a clock edge: state = IDLE, FIFO empty, cmd_level = 0, cmd_ready = 0, and bk_wstart = bk_rstart = rsp_valid = 0.
REQ-037 Also on reset: all bk_* address/data/strobe outputs, rsp_wr and rsp_rdata SHALL be 0.
REQ-038 Reset during any state SHALL discard queued and outstanding commands without emitting a response. The integrating top SHALL reset the downstream master on the same reset.
REQ-039 cmd_ready SHALL become 1 in the first cycle after reset deasserts.

Structure
REQ-040 Shared package axilite_pkg SHALL hold the FSM state enum and the DEPTH default constant.
REQ-041 The FIFO SHALL be a separate sub-module, axilite_cmd_fifo (push, pop, full, empty, level), instantiated once.

Verification
REQ-042 Single write: cmd (wr=1, addr 0x3000_0010, data 0xDEAD_BEEF, strb 0xF) at T -> bk_wstart at T+2 with those values; bk_wdone at T+6 -> rsp_valid at T+7, rsp_wr=1, rsp_rdata=0.
REQ-043 Single read: read 0x3000_0020; bk_rdone with bk_rdata=0x1234_5678 -> rsp_rdata=0x1234_5678, rsp_wr=0.
REQ-044 Fill: 5 commands with DEPTH=4 while the first is stalled in WAIT_DONE -> 4 more accepted (1 current + 4 queued), cmd_ready=0, cmd_level=4; all 5 complete in order.
REQ-045 Backpressure and spurious dones: rsp_ready=0 for 10 cycles -> rsp_valid and rsp_rdata held; stray bk_rdone during a write -> ignored, no response.
REQ-046 Reset mid-WAIT_DONE with 2 queued -> next cycle cmd_level=0, no response, then a fresh command completes normally.
